// File: rtl/slab_reduce.sv
// slab_reduce: sequences one shared less_than comparator to reduce slab times to t_entry/t_exit and a hit flag.
// Optional SLAB_REDUCE_EARLY_EXIT_EN skips the final comparison once the interval is known to be empty.
module slab_reduce #(
    parameter int WIDTH   = 36,
    parameter int CMP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   tnear_x,
    input  logic [WIDTH:0]   tnear_y,
    input  logic [WIDTH:0]   tnear_z,
    input  logic [WIDTH:0]   tfar_x,
    input  logic [WIDTH:0]   tfar_y,
    input  logic [WIDTH:0]   tfar_z,
    output logic [WIDTH:0]   cmp_a,
    output logic [WIDTH:0]   cmp_b,
    input  logic             cmp_less,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             hit,
    output logic [WIDTH:0]   t_entry,
    output logic [WIDTH:0]   t_exit
);
    localparam int WW = $clog2(CMP_LAT + 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t state, state_nx;
    logic [WIDTH:0] nx, ny, nz, fx, fy, fz, tmin, tmax, ntmin, ntmax, na, nb;
    logic [2:0] step;
    logic [WW-1:0] wcnt;
    logic c4, c5, accept, last, fin, skip;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (accept ? CMP : IDLE) :
                   state == CMP  ? (fin ? DONE : CMP) :
                                   (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready = (state == IDLE) & ~rst;
    end

    // step 6 is a one-cycle finish slot that publishes the reduced results
    always_comb begin
        accept = in_valid & in_ready;
        last   = (state == CMP) && (step <= 3'd5) && (wcnt == WW'(CMP_LAT));
        fin    = (state == CMP) && (step == 3'd6);
`ifdef SLAB_REDUCE_EARLY_EXIT_EN
        skip   = (step == 3'd4) && !cmp_less;
`else
        skip   = 1'b0;
`endif
        ntmin  = step == 3'd0 ? (cmp_less ? ny : nx) :
                 step == 3'd1 ? (cmp_less ? nz : tmin) : tmin;
        ntmax  = step == 3'd2 ? (cmp_less ? fx : fy) :
                 step == 3'd3 ? (cmp_less ? fz : tmax) : tmax;
        na     = step == 3'd0 ? ntmin :
                 step == 3'd1 ? fx :
                 step == 3'd2 ? fz :
                 step == 3'd3 ? tmin :
                 step == 3'd4 ? '0 : cmp_a;
        nb     = step == 3'd0 ? nz :
                 step == 3'd1 ? fy :
                 step == 3'd2 ? ntmax :
                 step == 3'd3 ? ntmax :
                 step == 3'd4 ? tmax : cmp_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {nx, ny, nz, fx, fy, fz} <= '0;
            {tmin, tmax, cmp_a, cmp_b, t_entry, t_exit} <= '0;
            {c4, c5, hit, out_valid} <= '0;
            step <= '0;
            wcnt <= '0;
        end else begin
            if (accept) begin
                {nx, ny, nz} <= {tnear_x, tnear_y, tnear_z};
                {fx, fy, fz} <= {tfar_x, tfar_y, tfar_z};
                cmp_a <= tnear_x;
                cmp_b <= tnear_y;
                step <= '0;
                wcnt <= '0;
            end
            if (state == CMP && step != 3'd6) begin
                wcnt <= last ? '0 : wcnt + WW'(1);
                if (last) begin
                    tmin  <= ntmin;
                    tmax  <= ntmax;
                    cmp_a <= na;
                    cmp_b <= nb;
                    step  <= skip ? 3'd6 : step + 3'd1;
                    if (step == 3'd4) c4 <= cmp_less;
                    if (step == 3'd5) c5 <= cmp_less;
                end
            end
            if (fin) begin
                hit       <= c4 & c5;
                t_entry   <= tmin;
                t_exit    <= tmax;
                out_valid <= 1'b1;
            end
            if (state == DONE && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_slab_reduce.sv
// tb_slab_reduce: directed and random checks of slab_reduce against a real-valued reference and a 3-stage comparator model.
module tb_slab_reduce;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cmp_less;
    logic [36:0] tnx = 0, tny = 0, tnz = 0, tfx = 0, tfy = 0, tfz = 0;
    logic [36:0] cmp_a, cmp_b, t_entry, t_exit;
    logic in_ready, out_valid, hit;
    logic [2:0] pipe = 0;
    int total = 0, passed = 0, fails = 0;
    logic [36:0] e_entry, e_exit;
    logic e_hit;
    int e_lat;

    localparam logic [36:0] H05 = 37'h9FF000000, H1 = 37'h9FF800000, H2 = 37'hA00000000;
    localparam logic [36:0] H3 = 37'hA00400000, M1 = 37'hDFF800000;

    slab_reduce dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .tnear_x(tnx), .tnear_y(tny), .tnear_z(tnz),
        .tfar_x(tfx), .tfar_y(tfy), .tfar_z(tfz),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less),
        .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .t_entry(t_entry), .t_exit(t_exit)
    );

    always #5 clk = ~clk;

    function automatic real fval(input logic [36:0] v);
        logic [63:0] d;
        d = {v[34], v[33:23], v[22:0], 29'b0};
        return v[36:35] == 2'b00 ? 0.0 : $bitstoreal(d);
    endfunction

    // strict A<B; any non-finite operand makes the difference non-normal, so "not less"
    function automatic logic lt(input logic [36:0] a, input logic [36:0] b);
        if (a[36:35] > 2'b01 || b[36:35] > 2'b01) return 1'b0;
        return fval(a) < fval(b);
    endfunction

    always @(posedge clk) pipe <= {pipe[1:0], lt(cmp_a, cmp_b)};
    assign cmp_less = pipe[2];

    function automatic logic [36:0] rnd_val(input bit pos);
        logic [10:0] e;
        e = 11'(1020 + $urandom_range(0, 6));
        return {2'b01, pos ? 1'b0 : 1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reference();
        real ne, fe;
        e_entry = tnx;
        if (fval(tny) > fval(e_entry)) e_entry = tny;
        if (fval(tnz) > fval(e_entry)) e_entry = tnz;
        e_exit = tfx;
        if (fval(tfy) < fval(e_exit)) e_exit = tfy;
        if (fval(tfz) < fval(e_exit)) e_exit = tfz;
        ne = fval(e_entry);
        fe = fval(e_exit);
        e_hit = (ne < fe) && (0.0 < fe);
`ifdef SLAB_REDUCE_EARLY_EXIT_EN
        e_lat = (ne < fe) ? 25 : 21;
`else
        e_lat = 25;
`endif
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 60);
        chk({tag, " latency"}, 64'(n), 64'(e_lat));
        chk({tag, " hit"}, 64'(hit), 64'(e_hit));
        chk({tag, " t_entry"}, 64'(t_entry), 64'(e_entry));
        chk({tag, " t_exit"}, 64'(t_exit), 64'(e_exit));
    endtask

    task automatic send(input logic [36:0] a, b, c, d, e, f, input string tag);
        int n;
        {tnx, tny, tnz, tfx, tfy, tfz} = {a, b, c, d, e, f};
        reference();
        in_valid = 1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " accept"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 0;
        wait_result(tag);
    endtask

    task automatic ack(input string tag);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, " ack out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, " ack in_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'(0));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset hit", 64'(hit), 64'(0));
        chk("reset t_entry", 64'(t_entry), 64'(0));
        chk("reset t_exit", 64'(t_exit), 64'(0));
        chk("reset cmp_a", 64'(cmp_a), 64'(0));
        chk("reset cmp_b", 64'(cmp_b), 64'(0));
        rst = 0;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'(1));

        send(H05, H1, H05, H3, H2, H3, "hit");
        chk("hit entry const", 64'(t_entry), 64'(H1));
        chk("hit exit const", 64'(t_exit), 64'(H2));
        chk("hit flag const", 64'(hit), 64'(1));
        ack("hit");

        send(H2, H05, H05, H1, H3, H3, "empty");
        chk("empty hit const", 64'(hit), 64'(0));
        ack("empty");

        send(M1, M1, M1, M1, M1, M1, "behind");
        chk("behind entry const", 64'(t_entry), 64'(M1));
        chk("behind exit const", 64'(t_exit), 64'(M1));
        ack("behind");

        // backpressure: result must hold while a competing request is offered
        send(H05, H05, H1, H3, H3, H2, "bp");
        {tnx, tny, tnz, tfx, tfy, tfz} = {H3, H3, H3, H05, H05, H05};
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp out_valid", 64'(out_valid), 64'(1));
            chk("bp in_ready", 64'(in_ready), 64'(0));
            chk("bp hold", {26'b0, hit, t_entry}, {26'b0, e_hit, e_entry});
            chk("bp hold exit", 64'(t_exit), 64'(e_exit));
        end
        in_valid = 0;
        ack("bp");
        @(posedge clk); #1;
        chk("bp single handshake", 64'(out_valid), 64'(0));

        // reset during step 2
        {tnx, tny, tnz, tfx, tfy, tfz} = {H05, H1, H05, H3, H2, H3};
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        chk("midrst out_valid", 64'(out_valid), 64'(0));
        chk("midrst cmp_a", 64'(cmp_a), 64'(0));
        chk("midrst cmp_b", 64'(cmp_b), 64'(0));
        rst = 0;
        #1;
        chk("midrst idle", 64'(in_ready), 64'(1));
        repeat (30) @(posedge clk);
        #1;
        chk("midrst no output", 64'(out_valid), 64'(0));
        send(H1, H05, H05, H2, H3, H3, "after rst");
        ack("after rst");

        // back-to-back with in_valid held and out_ready high
        begin
            logic [36:0] q2 [6];
            q2 = '{H05, H05, H05, H1, H2, H3};
            out_ready = 1;
            {tnx, tny, tnz, tfx, tfy, tfz} = {H05, H1, H05, H3, H2, H3};
            reference();
            in_valid = 1;
            @(posedge clk); #1;
            {tnx, tny, tnz, tfx, tfy, tfz} = {q2[0], q2[1], q2[2], q2[3], q2[4], q2[5]};
            wait_result("b2b first");
            @(posedge clk); #1;
            chk("b2b handshake", 64'(out_valid), 64'(0));
            chk("b2b in_ready", 64'(in_ready), 64'(1));
            reference();
            @(posedge clk); #1;
            in_valid = 0;
            chk("b2b second accepted", 64'(in_ready), 64'(0));
            wait_result("b2b second");
            out_ready = 0;
            ack("b2b second");
        end

        for (int k = 0; k < 10; k++) begin
            send(rnd_val(0), rnd_val(0), rnd_val(0),
                 rnd_val($urandom_range(0, 3) != 0), rnd_val($urandom_range(0, 3) != 0),
                 rnd_val($urandom_range(0, 3) != 0), "rand");
            ack("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
